// File: rtl/rand_range.sv
// rtl/rand_range.sv - rejection-sampled uniform integers in [MIN, MAX] from a 32-bit PRNG word, show-ahead FIFO output.
// Optional: define RAND_RANGE_NO_REPEAT_EN to reject candidates equal to the last pushed value.
module rand_range #(
   parameter int OUT_W      = 10,
   parameter int MIN        = 0,
   parameter int MAX        = 639,
   parameter int DEPTH      = 4,
   parameter int WARMUP_CYC = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [31:0]              prng,
   output logic                     prng_en,
   output logic                     rnd_valid,
   input  logic                     rnd_ready,
   output logic [OUT_W-1:0]         rnd_data,
   output logic [$clog2(DEPTH):0]   fill,
   output logic [15:0]              reject_cnt
);

   localparam int RANGE = MAX - MIN + 1;
   localparam int K     = $clog2(RANGE);
   localparam int AW    = $clog2(DEPTH);
   localparam int FW    = AW + 1;
   localparam int WCW   = $clog2(WARMUP_CYC) + 1;

   localparam logic [K-1:0]   SPAN  = K'(MAX - MIN);
   localparam logic [FW-1:0]  FULL  = FW'(DEPTH);
   localparam logic [WCW-1:0] WLAST = WCW'(WARMUP_CYC - 1);

   typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

   state_t            state, state_nx;
   logic [WCW-1:0]    warm_cnt;
   logic [OUT_W-1:0]  mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr, rd_nx;
   logic [FW-1:0]     fill_nx;
   logic [OUT_W-1:0]  head_nx;

   logic [K-1:0]      cand;
   logic [OUT_W-1:0]  cand_val;
   logic              in_range, repeat_hit, running, push, pop, reject;
   logic              unused_prng_low;

   // Only the top K bits drive the candidate; the rest of the word is ignored.
   assign cand            = prng[31 -: K];
   assign unused_prng_low = ^prng[31-K:0];
   assign cand_val        = OUT_W'(32'(cand) + 32'(MIN));
   assign in_range        = (cand <= SPAN);
   assign running         = (state == RUN);

`ifdef RAND_RANGE_NO_REPEAT_EN
   logic [OUT_W-1:0]  last_pushed;
   logic              last_valid;

   assign repeat_hit = last_valid && (cand_val == last_pushed);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_pushed <= '0;
         last_valid  <= 1'b0;
      end else if (push) begin
         last_pushed <= cand_val;
         last_valid  <= 1'b1;
      end
   end
`else
   assign repeat_hit = 1'b0;
`endif

   // A full FIFO blocks the push even when a pop happens in the same cycle.
   assign reject    = running && (!in_range || repeat_hit);
   assign push      = running && in_range && !repeat_hit && (fill < FULL);
   assign rnd_valid = (fill != '0);
   assign pop       = rnd_valid && rnd_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = WARMUP;
         WARMUP:  if (warm_cnt == WLAST) state_nx = RUN;
         RUN:     state_nx = RUN;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         warm_cnt   <= '0;
         prng_en    <= 1'b0;
         reject_cnt <= '0;
      end else begin
         if (state == WARMUP && warm_cnt != WLAST) warm_cnt <= warm_cnt + WCW'(1);
         if (state == IDLE && start) prng_en <= 1'b1;
         if (reject && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 16'd1;
      end
   end

   // Registered head: bypass the write when the incoming entry becomes the head.
   always_comb begin
      rd_nx   = pop ? rd_ptr + AW'(1) : rd_ptr;
      fill_nx = fill;
      case ({push, pop})
         2'b10:   fill_nx = fill + FW'(1);
         2'b01:   fill_nx = fill - FW'(1);
         default: fill_nx = fill;
      endcase
      head_nx = (push && wr_ptr == rd_nx) ? cand_val : mem[rd_nx];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fill     <= '0;
         rnd_data <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= cand_val;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_nx;
         fill   <= fill_nx;
         if (fill_nx != '0) rnd_data <= head_nx;
      end
   end

endmodule

// File: tb/tb_rand_range.sv
// tb/tb_rand_range.sv - self-checking bench for rand_range (defaults and MIN=100 instance).
module tb_rand_range;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] prng = 32'h0;
   logic        rnd_ready = 1'b0;

   logic        prng_en, rnd_valid;
   logic [9:0]  rnd_data;
   logic [2:0]  fill;
   logic [15:0] reject_cnt;

   logic        prng_en_m, rnd_valid_m;
   logic [9:0]  rnd_data_m;
   logic [2:0]  fill_m;
   logic [15:0] reject_cnt_m;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] w;
      logic        acc;
      logic [9:0]  ev0;
      logic [9:0]  ev1;
   } vec_t;

   vec_t       tbl [9];
   vec_t       rej_vec;
   logic [9:0] q0 [$];
   logic [9:0] q1 [$];
   int         m_fill = 0;
   int         exp_rej = 0;
   logic       last_v = 1'b0;
   logic [9:0] last_c = '0;
   int         rej_before;

   rand_range dut (
      .clk(clk), .reset_n(reset_n), .start(start), .prng(prng),
      .prng_en(prng_en), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
      .rnd_data(rnd_data), .fill(fill), .reject_cnt(reject_cnt)
   );

   rand_range #(.MIN(100), .MAX(739)) dut_m (
      .clk(clk), .reset_n(reset_n), .start(start), .prng(prng),
      .prng_en(prng_en_m), .rnd_valid(rnd_valid_m), .rnd_ready(rnd_ready),
      .rnd_data(rnd_data_m), .fill(fill_m), .reject_cnt(reject_cnt_m)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [9:0] c, input logic [21:0] low);
      vec_t v;
      v.w   = {c, low};
      v.acc = (c <= 10'd639);
      v.ev0 = c;
      v.ev1 = c + 10'd100;
      return v;
   endfunction

   // One RUN cycle: check outputs, retire a popped entry, then drive the next word.
   task automatic cycle(input vec_t v, input logic rdy);
      logic pop, push;
      logic [9:0] e0, e1;
      chk("fill", 32'(fill), 32'(m_fill));
      chk("valid", 32'(rnd_valid), 32'(m_fill != 0));
      chk("valid_min", 32'(rnd_valid_m), 32'(m_fill != 0));
      chk("reject_cnt", 32'(reject_cnt), 32'(exp_rej));
      pop = (m_fill != 0) && rdy;
      if (pop && q0.size() > 0) begin
         e0 = q0.pop_front();
         e1 = q1.pop_front();
         chk("data", 32'(rnd_data), 32'(e0));
         chk("data_min", 32'(rnd_data_m), 32'(e1));
      end
      push = 1'b0;
      if (!v.acc) exp_rej++;
`ifdef RAND_RANGE_NO_REPEAT_EN
      else if (last_v && v.ev0 == last_c) exp_rej++;
`endif
      else if (m_fill < 4) begin
         push = 1'b1;
         q0.push_back(v.ev0);
         q1.push_back(v.ev1);
         last_c = v.ev0;
         last_v = 1'b1;
      end
      m_fill = m_fill + int'(push) - int'(pop);
      prng = v.w;
      rnd_ready = rdy;
      @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{32'h12345678, 1'b1, 10'd72,  10'd172};
      tbl[1] = '{32'h9FC00000, 1'b1, 10'd639, 10'd739};
      tbl[2] = '{32'hA0000000, 1'b0, 10'd0,   10'd0};
      tbl[3] = '{32'h00000000, 1'b1, 10'd0,   10'd100};
      tbl[4] = '{32'h9FFFFFFF, 1'b1, 10'd639, 10'd739};
      tbl[5] = '{32'hFFC00000, 1'b0, 10'd0,   10'd0};
      tbl[6] = '{32'h003FFFFF, 1'b1, 10'd0,   10'd100};
      tbl[7] = '{32'h40000000, 1'b1, 10'd256, 10'd356};
      tbl[8] = '{32'h7FFFFFFF, 1'b1, 10'd511, 10'd611};
      rej_vec = '{32'hFFC00000, 1'b0, 10'd0, 10'd0};

      // Reset held, start toggling
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_fill", 32'(fill), 0);
      chk("rst_async_data", 32'(rnd_data), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = ~start;
         chk("rst_prng_en", 32'(prng_en), 0);
         chk("rst_valid", 32'(rnd_valid), 0);
         chk("rst_fill", 32'(fill), 0);
         chk("rst_reject", 32'(reject_cnt), 0);
      end
      @(negedge clk);
      start = 1'b0;
      reset_n = 1'b1;
      prng = 32'h12345678;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_prng_en", 32'(prng_en), 0);
         chk("idle_valid", 32'(rnd_valid), 0);
      end

      // Start timing: start high after edge 0, sampled at edge 1
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_prng_en", 32'(prng_en), 1);
      repeat (8) @(negedge clk);
      chk("edge9_valid", 32'(rnd_valid), 0);
      @(negedge clk);
      chk("edge10_valid", 32'(rnd_valid), 1);
      chk("edge10_data", 32'(rnd_data), 72);
      chk("edge10_data_min", 32'(rnd_data_m), 172);
      chk("edge10_fill", 32'(fill), 1);
      m_fill = 1;
      q0.push_back(10'd72);
      q1.push_back(10'd172);
      last_c = 10'd72;
      last_v = 1'b1;

      // Full and drop, then drain in order with pushes resuming
      for (int i = 0; i < 5; i++) cycle(mk(10'(200 + i), 22'h0), 1'b0);
      chk("full_fill", 32'(fill), 4);
      chk("full_reject", 32'(reject_cnt), 0);
      for (int i = 0; i < 6; i++) cycle(mk(10'(300 + i), 22'h1), 1'b1);
      repeat (4) cycle(rej_vec, 1'b1);

      // Table vectors
      for (int i = 0; i < 9; i++) cycle(tbl[i], 1'b1);
      repeat (2) cycle(rej_vec, 1'b1);

      // Five rejects from empty
      rej_before = int'(reject_cnt);
      repeat (5) cycle(rej_vec, 1'b1);
      chk("reject5_cnt", 32'(reject_cnt), 32'(rej_before + 5));
      chk("reject5_valid", 32'(rnd_valid), 0);

      // Simultaneous push/pop at fill 2 across pointer wrap
      cycle(mk(10'd400, 22'h2), 1'b0);
      cycle(mk(10'd401, 22'h2), 1'b0);
      for (int i = 0; i < 14; i++) begin
         cycle(mk(10'((i * 53 + 7) % 640), 22'h15A5A), 1'b1);
         chk("pp_fill", 32'(fill), 2);
      end
      repeat (3) cycle(rej_vec, 1'b1);
      chk("drained_fill", 32'(fill), 0);

      // Constant word: repeats allowed only without the no-repeat option
      rej_before = exp_rej;
      repeat (6) cycle(mk(10'd72, 22'h345678), 1'b0);
`ifdef RAND_RANGE_NO_REPEAT_EN
      chk("norep_fill", 32'(fill), 1);
      chk("norep_reject", 32'(reject_cnt), 32'(rej_before + 5));
`else
      chk("rep_fill", 32'(fill), 4);
      chk("rep_reject", 32'(reject_cnt), 32'(rej_before));
`endif
      chk("rep_head", 32'(rnd_data), 72);

      // Reset mid-operation
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_fill", 32'(fill), 0);
      chk("mid_rst_prng_en", 32'(prng_en), 0);
      chk("mid_rst_valid", 32'(rnd_valid), 0);
      chk("mid_rst_reject", 32'(reject_cnt), 0);
      chk("mid_rst_data", 32'(rnd_data), 0);
      @(negedge clk);
      reset_n = 1'b1;
      prng = 32'h12345678;
      rnd_ready = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_idle_en", 32'(prng_en), 0);
      chk("post_rst_idle_fill", 32'(fill), 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("restart_edge9_valid", 32'(rnd_valid), 0);
      @(negedge clk);
      chk("restart_edge10_valid", 32'(rnd_valid), 1);
      chk("restart_edge10_data", 32'(rnd_data), 72);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
